// File: rtl/nv_ram_fifo_pkg.sv
// Shared widths and helpers for the RAM-backed valid/ready FIFO controller.
package nv_ram_fifo_pkg;

   localparam int unsigned FIFO_DW    = 32;
   localparam int unsigned FIFO_AW    = 5;
   localparam int unsigned FIFO_DEPTH = 32;
   localparam int unsigned FIFO_CW    = FIFO_AW + 1;

   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/nv_ram_fifo_rdpipe.sv
// Read pipeline tracking: s1 = address latched in RAM, s2 = data in RAM output register.
module nv_ram_fifo_rdpipe (
   input  logic clk,
   input  logic rst_n,
   input  logic issue_req_i,
   input  logic rd_prdy_i,
   output logic re_c_o,
   output logic ore_c_o,
   output logic rd_pvld_o
);

   logic s1_vld_q, s1_vld_d;
   logic s2_vld_q, s2_vld_d;

   // Capture into the output register whenever it is empty or being consumed.
   assign ore_c_o   = s1_vld_q & (~s2_vld_q | rd_prdy_i);
   assign re_c_o    = issue_req_i & (~s1_vld_q | ore_c_o);
   assign rd_pvld_o = s2_vld_q;

   always_comb begin
      s1_vld_d = s1_vld_q;
      s2_vld_d = s2_vld_q;
      if (re_c_o) begin
         s1_vld_d = 1'b1;
      end else if (ore_c_o) begin
         s1_vld_d = 1'b0;
      end
      if (ore_c_o) begin
         s2_vld_d = 1'b1;
      end else if (rd_prdy_i) begin
         s2_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         // A stalled output must stay valid.
         assert (!(s2_vld_q && !rd_prdy_i) || s2_vld_d);
      end
   end

endmodule

// File: rtl/nv_ram_rwsp_32x32_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 32x32 registered-read RAM.
// Optional NV_RAM_FIFO_CTRL_CUT_THROUGH_EN issues a same-cycle write straight to the read port.
module nv_ram_rwsp_32x32_fifo_ctrl
   import nv_ram_fifo_pkg::*;
#(
   parameter int unsigned DW = FIFO_DW,
   parameter int unsigned AW = FIFO_AW
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          wr_pvld,
   output logic          wr_prdy,
   input  logic [DW-1:0] wr_pd,
   output logic          rd_pvld,
   input  logic          rd_prdy,
   output logic [DW-1:0] rd_pd,
   output logic [AW-1:0] ram_wa,
   output logic          ram_we,
   output logic [DW-1:0] ram_di,
   output logic [AW-1:0] ram_ra,
   output logic          ram_re,
   output logic          ram_ore,
   input  logic [DW-1:0] ram_dout,
   input  logic [31:0]   pwrbus_ram_pd,
   output logic [31:0]   ram_pwrbus_pd
);

   localparam int unsigned DEPTH = fifo_depth(AW);
   localparam int unsigned CW    = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] ram_cnt_q, ram_cnt_d;
   logic [CW-1:0] unissued_q, unissued_d;
   logic          wr_prdy_q, wr_prdy_d;
   logic          issue_req_c;

   assign wr_prdy       = wr_prdy_q;
   assign ram_we        = wr_pvld & wr_prdy_q;
   assign ram_wa        = wr_ptr_q;
   assign ram_di        = wr_pd;
   assign ram_ra        = rd_ptr_q;
   assign rd_pd         = ram_dout;
   assign ram_pwrbus_pd = pwrbus_ram_pd;

`ifdef NV_RAM_FIFO_CTRL_CUT_THROUGH_EN
   // With nothing unissued rd_ptr==wr_ptr, so a same-edge write can be latched for read.
   assign issue_req_c = (unissued_q != '0) | ram_we;
`else
   assign issue_req_c = (unissued_q != '0);
`endif

   nv_ram_fifo_rdpipe u_rdpipe (
      .clk         (nvdla_core_clk),
      .rst_n       (nvdla_core_rstn),
      .issue_req_i (issue_req_c),
      .rd_prdy_i   (rd_prdy),
      .re_c_o      (ram_re),
      .ore_c_o     (ram_ore),
      .rd_pvld_o   (rd_pvld)
   );

   // Slots are released on ore only, so a latched-but-uncaptured address is never overwritten.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (ram_we) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (ram_re) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      ram_cnt_d  = ram_cnt_q + CW'(ram_we) - CW'(ram_ore);
      unissued_d = unissued_q + CW'(ram_we) - CW'(ram_re);
      wr_prdy_d  = (ram_cnt_d != CW'(DEPTH));
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         unissued_q <= '0;
         wr_prdy_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         unissued_q <= unissued_d;
         wr_prdy_q  <= wr_prdy_d;
         assert (ram_cnt_q <= CW'(DEPTH));
         assert (unissued_q <= ram_cnt_q);
      end
   end

endmodule

// File: tb/tb_nv_ram_rwsp_32x32_fifo_ctrl.sv
// Self-checking bench: behavioural RAM beside the controller, queue-based FIFO reference model.
module tb_nv_ram_rwsp_32x32_fifo_ctrl;

`ifdef NV_RAM_FIFO_CTRL_CUT_THROUGH_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif
   localparam int RAM_SLOTS = 32;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
   logic [31:0] wr_pd, rd_pd, ram_di, ram_dout;
   logic [4:0]  ram_wa, ram_ra;
   logic        ram_we, ram_re, ram_ore;
   logic [31:0] pwr_in, pwr_out;

   always #5 clk = ~clk;

   nv_ram_rwsp_32x32_fifo_ctrl dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wr_pvld         (wr_pvld),
      .wr_prdy         (wr_prdy),
      .wr_pd           (wr_pd),
      .rd_pvld         (rd_pvld),
      .rd_prdy         (rd_prdy),
      .rd_pd           (rd_pd),
      .ram_wa          (ram_wa),
      .ram_we          (ram_we),
      .ram_di          (ram_di),
      .ram_ra          (ram_ra),
      .ram_re          (ram_re),
      .ram_ore         (ram_ore),
      .ram_dout        (ram_dout),
      .pwrbus_ram_pd   (pwr_in),
      .ram_pwrbus_pd   (pwr_out)
   );

   // Two-port RAM with address latch and output register.
   logic [31:0] mem [0:31];
   logic [4:0]  ra_lat = '0;
   logic [31:0] dout_q = '0;
   always @(posedge clk) begin
      if (ram_we)  mem[ram_wa] <= ram_di;
      if (ram_re)  ra_lat      <= ram_ra;
      if (ram_ore) dout_q      <= mem[ra_lat];
   end
   assign ram_dout = dout_q;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q [$];
   bit          prev_stall = 1'b0;
   logic [31:0] prev_pd = '0;
   bit          s_rd_pvld, s_wr_fire, s_wr_prdy;
   int          cyc = 0;
   int          n_pop = 0;
   int          last_pop_cyc = 0;
   logic [31:0] last_pop_val = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at edge+1, sample at edge+3, update the model, advance to next edge+1.
   task automatic cycle(input logic wv, input logic [31:0] wd, input logic rr);
      int occ;
      wr_pvld = wv;
      wr_pd   = wd;
      rd_prdy = rr;
      #2;
      occ = q.size() - int'(rd_pvld);
      chk("wr_prdy", wr_prdy, occ != RAM_SLOTS);
      chk("ram_we", ram_we, wv && (occ != RAM_SLOTS));
      chk("pwrbus", pwr_out, pwr_in);
      if (rd_pvld && !rr) chk("ore_on_stall", ram_ore, 1'b0);
      if (prev_stall) begin
         chk("hold_pvld", rd_pvld, 1'b1);
         chk("hold_pd", rd_pd, prev_pd);
      end
      if (rd_pvld) begin
         if (q.size() == 0) chk("rd_pvld_empty", rd_pvld, 1'b0);
         else               chk("rd_pd", rd_pd, q[0]);
      end
      s_rd_pvld  = rd_pvld;
      s_wr_prdy  = wr_prdy;
      s_wr_fire  = wv && wr_prdy;
      prev_stall = rd_pvld && !rr;
      prev_pd    = rd_pd;
      if (rd_pvld && rr && q.size() > 0) begin
         last_pop_val = q.pop_front();
         n_pop++;
         last_pop_cyc = cyc;
      end
      if (s_wr_fire) q.push_back(wd);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 120 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
      chk(tag, q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, acc, sent, p0, c_first;
      logic [31:0] d;
      wr_pvld = 1'b1;
      wr_pd   = '0;
      rd_prdy = 1'b0;
      pwr_in  = $urandom;
      #1 rstn = 1'b0;
      #11;
      chk("rst_wr_prdy", wr_prdy, 1'b0);
      chk("rst_rd_pvld", rd_pvld, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_re", ram_re, 1'b0);
      chk("rst_ram_ore", ram_ore, 1'b0);
      wr_pvld = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;

      // Single word latency
      lat = 0;
      cycle(1'b1, 32'hA5A5_0001, 1'b1);
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         cycle(1'b0, '0, 1'b1);
         if (s_rd_pvld) lat = k;
      end
      chk("latency", lat, LAT);
      chk("first_word", last_pop_val, 32'hA5A5_0001);
      drain("t1_empty");

      // Capacity with consumer stalled
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 32'(acc), 1'b0);
         if (s_wr_fire) acc++;
      end
      chk("capacity", acc, 33);
      cycle(1'b1, 32'(acc), 1'b0);
      chk("full_no_accept", s_wr_fire, 1'b0);
      drain("t2_empty");
      chk("t2_last", last_pop_val, 32'd32);

      // Streaming throughput across pointer wrap
      sent = 0; p0 = n_pop; c_first = -1;
      for (int i = 0; i < 400 && (n_pop - p0) < 100; i++) begin
         d = $urandom;
         cycle(sent < 100, d, 1'b1);
         if (s_wr_fire) sent++;
         if (c_first < 0 && n_pop > p0) c_first = last_pop_cyc;
      end
      chk("stream_count", n_pop - p0, 100);
      chk("stream_rate", last_pop_cyc - c_first, 99);
      drain("t3_empty");

      // Alternating consumer ready
      sent = 0;
      for (int i = 0; i < 80; i++) begin
         d = $urandom;
         cycle(sent < 40, d, (i % 2) == 0);
         if (s_wr_fire) sent++;
      end
      drain("t4_empty");

      // Full FIFO, single pop frees one slot on the following cycle
      for (int i = 0; i < 60 && (i == 0 || s_wr_prdy); i++) cycle(1'b1, $urandom, 1'b0);
      chk("full_occ", q.size(), 33);
      cycle(1'b1, 32'hF00D_0001, 1'b1);
      chk("no_same_cycle_rise", s_wr_fire, 1'b0);
      cycle(1'b1, 32'hF00D_0001, 1'b0);
      chk("freed_slot_accept", s_wr_fire, 1'b1);
      cycle(1'b0, '0, 1'b0);
      chk("full_again", s_wr_prdy, 1'b0);
      drain("t5_empty");
      chk("freed_slot_data", last_pop_val, 32'hF00D_0001);

      // Reset mid-stream with data in flight
      for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0);
      #3 rstn = 1'b0;
      #1;
      chk("midrst_rd_pvld", rd_pvld, 1'b0);
      chk("midrst_wr_prdy", wr_prdy, 1'b0);
      chk("midrst_ram_re", ram_re, 1'b0);
      chk("midrst_ram_ore", ram_ore, 1'b0);
      chk("midrst_ram_we", ram_we, 1'b0);
      q.delete();
      prev_stall = 1'b0;
      wr_pvld = 1'b0;
      @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;
      chk("postrst_rd_pvld", rd_pvld, 1'b0);
      cycle(1'b1, 32'h1234_5678, 1'b1);
      drain("t6_empty");
      chk("postrst_word", last_pop_val, 32'h1234_5678);

      // Random traffic against the reference queue
      for (int i = 0; i < 400; i++) begin
         d = $urandom;
         cycle(1'($urandom_range(0, 1)), d, $urandom_range(0, 3) != 0);
      end
      drain("rand_empty");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
